// File: rtl/datapath_pkg.sv
// Shared datapath definitions for the PC sequencer and its neighbours:
// sequencer state encoding, PC increment, register-zero constant and the
// default reset vector.
package datapath_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      HALT  = 2'd2
   } seqState_t;

   localparam logic [31:0] PC_INCR              = 32'd4;
   localparam logic [4:0]  REG_ZERO             = 5'd0;
   localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle of the signals between the PC sequencer and the pipeline around it.
// The master modport is the sequencer side; the slave modport is the
// pipeline side (hazard/branch logic, PC register, IF/ID register).
// Optional macro PC_SEQ_PERF_COUNTERS_EN adds the CycleCount, StallCount and
// FlushCount outputs.
interface pc_sequencer_if;

   logic [31:0] PCCurrent;
   logic        BranchTaken;
   logic [31:0] BranchTarget;
   logic        Jump;
   logic [31:0] JumpTarget;
   logic        IDEX_MemRead;
   logic [4:0]  IDEX_Rt;
   logic [4:0]  IFID_Rs;
   logic [4:0]  IFID_Rt;
   logic        HaltReq;

   logic [31:0] NextAddress;
   logic        PCWrite;
   logic        IFIDWrite;
   logic        IFIDFlush;
   logic        IDEXFlush;
   logic        Halted;

`ifdef PC_SEQ_PERF_COUNTERS_EN
   logic [31:0] CycleCount;
   logic [31:0] StallCount;
   logic [31:0] FlushCount;
`endif

   modport master (
      input  PCCurrent, BranchTaken, BranchTarget, Jump, JumpTarget,
             IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, HaltReq,
      output NextAddress, PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, Halted
`ifdef PC_SEQ_PERF_COUNTERS_EN
      , output CycleCount, StallCount, FlushCount
`endif
   );

   modport slave (
      output PCCurrent, BranchTaken, BranchTarget, Jump, JumpTarget,
             IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, HaltReq,
      input  NextAddress, PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, Halted
`ifdef PC_SEQ_PERF_COUNTERS_EN
      , input CycleCount, StallCount, FlushCount
`endif
   );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard compare: the load in EX writes a register that the
// instruction in ID reads. Writes to register zero never create a hazard.
// Purely combinational so forwarding logic can reuse it.
module hazard_detect
   import datapath_pkg::*;
(
   input  logic       IDEX_MemRead,
   input  logic [4:0] IDEX_Rt,
   input  logic [4:0] IFID_Rs,
   input  logic [4:0] IFID_Rt,
   output logic       LoadUse
);

   // Hazard when a non-zero load destination matches either ID source
   always_comb begin
      LoadUse = IDEX_MemRead && (IDEX_Rt != REG_ZERO) &&
                ((IDEX_Rt == IFID_Rs) || (IDEX_Rt == IFID_Rt));
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: picks the next fetch address (sequential,
// branch, jump or hold), inserts load-use bubbles over one or more cycles,
// flushes IF/ID on redirects and freezes fetch after a halt until reset.
// Optional macro PC_SEQ_PERF_COUNTERS_EN adds saturating cycle, stall and
// flush counters.
module pc_sequencer
   import datapath_pkg::*;
#(
   parameter int          LOAD_STALL_CYCLES = 1,
   parameter logic [31:0] RESET_VECTOR      = RESET_VECTOR_DEFAULT
) (
   input  logic              Clk,
   input  logic              Reset,
   pc_sequencer_if.master    bus
);

   seqState_t  state, nextState;
   logic [2:0] stallCnt, stallCntNext;
   logic       luh;
   logic       stallHold;
   logic       redirect;

   hazard_detect u_hazard (
      .IDEX_MemRead (bus.IDEX_MemRead),
      .IDEX_Rt      (bus.IDEX_Rt),
      .IFID_Rs      (bus.IFID_Rs),
      .IFID_Rt      (bus.IFID_Rt),
      .LoadUse      (luh)
   );

   // State and stall counter register with synchronous reset
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= RUN;
         stallCnt <= 3'd0;
      end else begin
         state    <= nextState;
         stallCnt <= stallCntNext;
      end
   end

   // Prioritised next-state, next-address and pipeline control decision
   always_comb begin
      nextState       = state;
      stallCntNext    = stallCnt;
      bus.NextAddress = bus.PCCurrent + PC_INCR;
      bus.PCWrite     = 1'b0;
      bus.IFIDWrite   = 1'b0;
      bus.IFIDFlush   = 1'b0;
      bus.IDEXFlush   = 1'b0;
      bus.Halted      = 1'b0;
      stallHold       = 1'b0;
      redirect        = 1'b0;

      if (Reset) begin
         nextState       = RUN;
         stallCntNext    = 3'd0;
         bus.NextAddress = RESET_VECTOR;
         bus.IFIDFlush   = 1'b1;
         bus.IDEXFlush   = 1'b1;
      end else if (state == HALT) begin
         bus.PCWrite   = 1'b1;
         bus.IFIDWrite = 1'b1;
         bus.IDEXFlush = 1'b1;
         bus.Halted    = 1'b1;
      end else if (bus.HaltReq) begin
         bus.PCWrite   = 1'b1;
         bus.IFIDFlush = 1'b1;
         nextState     = HALT;
         stallCntNext  = 3'd0;
      end else if (bus.BranchTaken) begin
         bus.NextAddress = bus.BranchTarget;
         bus.IFIDFlush   = 1'b1;
         bus.IDEXFlush   = 1'b1;
         nextState       = RUN;
         stallCntNext    = 3'd0;
         redirect        = 1'b1;
      end else if (bus.Jump) begin
         bus.NextAddress = bus.JumpTarget;
         bus.IFIDFlush   = 1'b1;
         nextState       = RUN;
         stallCntNext    = 3'd0;
         redirect        = 1'b1;
      end else if (state == RUN && luh) begin
         bus.PCWrite   = 1'b1;
         bus.IFIDWrite = 1'b1;
         bus.IDEXFlush = 1'b1;
         stallHold     = 1'b1;
         if (LOAD_STALL_CYCLES > 1) begin
            stallCntNext = 3'(LOAD_STALL_CYCLES - 1);
            nextState    = STALL;
         end
      end else if (state == STALL) begin
         bus.PCWrite   = 1'b1;
         bus.IFIDWrite = 1'b1;
         bus.IDEXFlush = 1'b1;
         stallHold     = 1'b1;
         stallCntNext  = stallCnt - 3'd1;
         if (stallCnt == 3'd1) begin
            nextState = RUN;
         end
      end
   end

`ifdef PC_SEQ_PERF_COUNTERS_EN
   logic [31:0] cycleCount, stallCount, flushCount;

   assign bus.CycleCount = cycleCount;
   assign bus.StallCount = stallCount;
   assign bus.FlushCount = flushCount;

   // Saturating counters for non-halted cycles, bubble cycles and redirects
   always_ff @(posedge Clk) begin
      if (Reset) begin
         cycleCount <= 32'd0;
         stallCount <= 32'd0;
         flushCount <= 32'd0;
      end else begin
         if (state != HALT && cycleCount != 32'hFFFF_FFFF) begin
            cycleCount <= cycleCount + 32'd1;
         end
         if (stallHold && stallCount != 32'hFFFF_FFFF) begin
            stallCount <= stallCount + 32'd1;
         end
         if (redirect && flushCount != 32'hFFFF_FFFF) begin
            flushCount <= flushCount + 32'd1;
         end
      end
   end
`else
   logic unusedPerf;
   assign unusedPerf = stallHold ^ redirect;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer. Two instances share the stimulus:
// one with a 2-cycle load-use stall, one with a 3-cycle stall. Each step
// pushes the expected outputs of the selected instance onto a scoreboard
// queue; a negedge checker pops and compares them. Each instance has a
// small PC register model that loads NextAddress when PCWrite is low.
module tb_pc_sequencer;
   import datapath_pkg::*;

   logic Clk = 1'b0;
   logic Reset;

   always #5 Clk = ~Clk;

   logic        branchTaken;
   logic [31:0] branchTarget;
   logic        jump;
   logic [31:0] jumpTarget;
   logic        memRead;
   logic [4:0]  idexRt;
   logic [4:0]  ifidRs;
   logic [4:0]  ifidRt;
   logic        haltReq;
   logic [31:0] pcReg2 = 32'd0;
   logic [31:0] pcReg3 = 32'd0;

   pc_sequencer_if bus2 ();
   pc_sequencer_if bus3 ();

   assign bus2.PCCurrent    = pcReg2;
   assign bus2.BranchTaken  = branchTaken;
   assign bus2.BranchTarget = branchTarget;
   assign bus2.Jump         = jump;
   assign bus2.JumpTarget   = jumpTarget;
   assign bus2.IDEX_MemRead = memRead;
   assign bus2.IDEX_Rt      = idexRt;
   assign bus2.IFID_Rs      = ifidRs;
   assign bus2.IFID_Rt      = ifidRt;
   assign bus2.HaltReq      = haltReq;

   assign bus3.PCCurrent    = pcReg3;
   assign bus3.BranchTaken  = branchTaken;
   assign bus3.BranchTarget = branchTarget;
   assign bus3.Jump         = jump;
   assign bus3.JumpTarget   = jumpTarget;
   assign bus3.IDEX_MemRead = memRead;
   assign bus3.IDEX_Rt      = idexRt;
   assign bus3.IFID_Rs      = ifidRs;
   assign bus3.IFID_Rt      = ifidRt;
   assign bus3.HaltReq      = haltReq;

   pc_sequencer #(.LOAD_STALL_CYCLES(2), .RESET_VECTOR(32'h0000_0000)) dut2 (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus2)
   );

   pc_sequencer #(.LOAD_STALL_CYCLES(3), .RESET_VECTOR(32'h0000_0000)) dut3 (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus3)
   );

   // PC register models: load the selected address unless held
   always @(posedge Clk) begin
      if (!bus2.PCWrite) pcReg2 <= bus2.NextAddress;
      if (!bus3.PCWrite) pcReg3 <= bus3.NextAddress;
   end

   typedef struct {
      int          dutSel;
      string       tag;
      logic [31:0] nextAddr;
      logic [4:0]  flags;
   } exp_t;

   exp_t expQ[$];
   exp_t cur;
   int   checkCount = 0;
   int   failCount  = 0;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Flags are {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, Halted}
   task automatic applyStimulus(input string tag, input int dutSel,
                                input logic rst, input logic br,
                                input logic [31:0] brT, input logic jmp,
                                input logic [31:0] jT, input logic mr,
                                input logic [4:0] eRt, input logic [4:0] rs,
                                input logic [4:0] rt, input logic halt,
                                input logic [31:0] expAddr,
                                input logic [4:0] expFlags);
      exp_t e;
      Reset        = rst;
      branchTaken  = br;
      branchTarget = brT;
      jump         = jmp;
      jumpTarget   = jT;
      memRead      = mr;
      idexRt       = eRt;
      ifidRs       = rs;
      ifidRt       = rt;
      haltReq      = halt;
      e.dutSel     = dutSel;
      e.tag        = tag;
      e.nextAddr   = expAddr;
      e.flags      = expFlags;
      expQ.push_back(e);
      @(posedge Clk);
      #1;
   endtask

   // Scoreboard checker: compare the selected instance midway through the cycle
   always @(negedge Clk) begin
      if (expQ.size() > 0) begin
         cur = expQ.pop_front();
         if (cur.dutSel == 2) begin
            checkOutput({cur.tag, " NextAddress"}, bus2.NextAddress, cur.nextAddr);
            checkOutput({cur.tag, " PCWrite"},   {31'd0, bus2.PCWrite},   {31'd0, cur.flags[4]});
            checkOutput({cur.tag, " IFIDWrite"}, {31'd0, bus2.IFIDWrite}, {31'd0, cur.flags[3]});
            checkOutput({cur.tag, " IFIDFlush"}, {31'd0, bus2.IFIDFlush}, {31'd0, cur.flags[2]});
            checkOutput({cur.tag, " IDEXFlush"}, {31'd0, bus2.IDEXFlush}, {31'd0, cur.flags[1]});
            checkOutput({cur.tag, " Halted"},    {31'd0, bus2.Halted},    {31'd0, cur.flags[0]});
         end else begin
            checkOutput({cur.tag, " NextAddress"}, bus3.NextAddress, cur.nextAddr);
            checkOutput({cur.tag, " PCWrite"},   {31'd0, bus3.PCWrite},   {31'd0, cur.flags[4]});
            checkOutput({cur.tag, " IFIDWrite"}, {31'd0, bus3.IFIDWrite}, {31'd0, cur.flags[3]});
            checkOutput({cur.tag, " IFIDFlush"}, {31'd0, bus3.IFIDFlush}, {31'd0, cur.flags[2]});
            checkOutput({cur.tag, " IDEXFlush"}, {31'd0, bus3.IDEXFlush}, {31'd0, cur.flags[1]});
            checkOutput({cur.tag, " Halted"},    {31'd0, bus3.Halted},    {31'd0, cur.flags[0]});
         end
      end
   end

   initial begin
      Reset = 1'b1;
      branchTaken = 1'b0; branchTarget = 32'd0; jump = 1'b0; jumpTarget = 32'd0;
      memRead = 1'b0; idexRt = 5'd0; ifidRs = 5'd0; ifidRt = 5'd0; haltReq = 1'b0;
      @(posedge Clk);
      #1;
      $display("[TB] reset and sequential fetch");
      //            tag         dut rst br brT          jmp jT           mr eRt    rs     rt     hlt addr          flags
      applyStimulus("rst1",     2, 1, 0, 32'h0,       0, 32'h0,       0, 5'd0,  5'd0,  5'd0,  0, 32'h0,        5'b00110);
      applyStimulus("rst2",     2, 1, 0, 32'h0,       0, 32'h0,       0, 5'd0,  5'd0,  5'd0,  0, 32'h0,        5'b00110);
      applyStimulus("seq4",     2, 0, 0, 32'h0,       0, 32'h0,       0, 5'd0,  5'd0,  5'd0,  0, 32'h4,        5'b00000);
      applyStimulus("seq8",     2, 0, 0, 32'h0,       0, 32'h0,       0, 5'd0,  5'd0,  5'd0,  0, 32'h8,        5'b00000);
      applyStimulus("seq12",    2, 0, 0, 32'h0,       0, 32'h0,       0, 5'd0,  5'd0,  5'd0,  0, 32'hC,        5'b00000);

      $display("[TB] load-use stall of two cycles");
      applyStimulus("luh1",     2, 0, 0, 32'h0,       0, 32'h0,       1, 5'd8,  5'd8,  5'd0,  0, 32'h10,       5'b11010);
      applyStimulus("luh2",     2, 0, 0, 32'h0,       0, 32'h0,       0, 5'd8,  5'd8,  5'd0,  0, 32'h10,       5'b11010);
      applyStimulus("luhEnd",   2, 0, 0, 32'h0,       0, 32'h0,       0, 5'd0,  5'd0,  5'd0,  0, 32'h10,       5'b00000);
      applyStimulus("luhSeq",   2, 0, 0, 32'h0,       0, 32'h0,       0, 5'd0,  5'd0,  5'd0,  0, 32'h14,       5'b00000);

      $display("[TB] hazard boundary cases");
      applyStimulus("rtZero",   2, 0, 0, 32'h0,       0, 32'h0,       1, 5'd0,  5'd0,  5'd0,  0, 32'h18,       5'b00000);
      applyStimulus("rtMatch1", 2, 0, 0, 32'h0,       0, 32'h0,       1, 5'd5,  5'd3,  5'd5,  0, 32'h1C,       5'b11010);
      applyStimulus("rtMatch2", 2, 0, 0, 32'h0,       0, 32'h0,       0, 5'd0,  5'd0,  5'd0,  0, 32'h1C,       5'b11010);
      applyStimulus("rtMatch3", 2, 0, 0, 32'h0,       0, 32'h0,       0, 5'd0,  5'd0,  5'd0,  0, 32'h1C,       5'b00000);
      applyStimulus("noMatch",  2, 0, 0, 32'h0,       0, 32'h0,       1, 5'd5,  5'd6,  5'd7,  0, 32'h20,       5'b00000);
      applyStimulus("noLoad",   2, 0, 0, 32'h0,       0, 32'h0,       0, 5'd9,  5'd9,  5'd9,  0, 32'h24,       5'b00000);

      $display("[TB] branch cancels a three-cycle stall");
      applyStimulus("rst3",     3, 1, 0, 32'h0,       0, 32'h0,       0, 5'd0,  5'd0,  5'd0,  0, 32'h0,        5'b00110);
      applyStimulus("s3luh",    3, 0, 0, 32'h0,       0, 32'h0,       1, 5'd8,  5'd8,  5'd0,  0, 32'h4,        5'b11010);
      applyStimulus("s3br",     3, 0, 1, 32'h40,      0, 32'h0,       0, 5'd0,  5'd0,  5'd0,  0, 32'h40,       5'b00110);
      applyStimulus("s3after",  3, 0, 0, 32'h0,       0, 32'h0,       0, 5'd0,  5'd0,  5'd0,  0, 32'h44,       5'b00000);
      applyStimulus("s3full1",  3, 0, 0, 32'h0,       0, 32'h0,       1, 5'd4,  5'd4,  5'd0,  0, 32'h48,       5'b11010);
      applyStimulus("s3full2",  3, 0, 0, 32'h0,       0, 32'h0,       0, 5'd0,  5'd0,  5'd0,  0, 32'h48,       5'b11010);
      applyStimulus("s3full3",  3, 0, 0, 32'h0,       0, 32'h0,       0, 5'd0,  5'd0,  5'd0,  0, 32'h48,       5'b11010);
      applyStimulus("s3resume", 3, 0, 0, 32'h0,       0, 32'h0,       0, 5'd0,  5'd0,  5'd0,  0, 32'h48,       5'b00000);

      $display("[TB] branch versus jump and address wrap");
      applyStimulus("brJmp",    3, 0, 1, 32'h100,     1, 32'h200,     0, 5'd0,  5'd0,  5'd0,  0, 32'h100,      5'b00110);
      applyStimulus("jmp",      3, 0, 0, 32'h0,       1, 32'h200,     0, 5'd0,  5'd0,  5'd0,  0, 32'h200,      5'b00100);
      applyStimulus("jmpSeq",   3, 0, 0, 32'h0,       0, 32'h0,       0, 5'd0,  5'd0,  5'd0,  0, 32'h204,      5'b00000);
      applyStimulus("jmpTop",   3, 0, 0, 32'h0,       1, 32'hFFFFFFFC, 0, 5'd0,  5'd0,  5'd0,  0, 32'hFFFFFFFC, 5'b00100);
      applyStimulus("wrap",     3, 0, 0, 32'h0,       0, 32'h0,       0, 5'd0,  5'd0,  5'd0,  0, 32'h0,        5'b00000);

      $display("[TB] halt is sticky until reset");
      applyStimulus("haltReq",  3, 0, 0, 32'h0,       0, 32'h0,       0, 5'd0,  5'd0,  5'd0,  1, 32'h4,        5'b10100);
      applyStimulus("halted1",  3, 0, 1, 32'h40,      0, 32'h0,       0, 5'd0,  5'd0,  5'd0,  0, 32'h4,        5'b11011);
      applyStimulus("halted2",  3, 0, 1, 32'h40,      1, 32'h80,      1, 5'd8,  5'd8,  5'd0,  0, 32'h4,        5'b11011);
      applyStimulus("haltRst",  3, 1, 0, 32'h0,       0, 32'h0,       0, 5'd0,  5'd0,  5'd0,  0, 32'h0,        5'b00110);
      applyStimulus("postRst",  3, 0, 0, 32'h0,       0, 32'h0,       0, 5'd0,  5'd0,  5'd0,  0, 32'h4,        5'b00000);

      checkOutput("scoreboard drained", expQ.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Controller for the 32-bit program counter register.
- Each cycle it selects the next fetch address and drives the PC's `PCWrite` hold control (1 = hold, 0 = load `Address`).
- Selects among: sequential, branch target, jump target, hold.
- Detects load-use hazards and sequences multi-cycle stalls, IF/ID flushes and a sticky halt.
- Sits between the hazard/branch logic of ID/EX and the PC plus the IF/ID pipeline register.

Parameters:
- `LOAD_STALL_CYCLES`, 1: bubbles inserted per load-use hazard (1..7).
- `RESET_VECTOR`, 32'h00000000: address driven on `NextAddress` while `Reset` is high.

Ports:
- `Clk`  input  1  clock; all state updates on posedge.
- `Reset`  input  1  synchronous, active-high reset.
- `PCCurrent`  input  32  current PC register output.
- `BranchTaken`  input  1  resolved taken branch (EX stage).
- `BranchTarget`  input  32  branch target address.
- `Jump`  input  1  jump decoded in ID.
- `JumpTarget`  input  32  jump target address.
- `IDEX_MemRead`  input  1  instruction in EX is a load.
- `IDEX_Rt`  input  5  destination register of that load.
- `IFID_Rs`  input  5  source register of the instruction in ID.
- `IFID_Rt`  input  5  source register of the instruction in ID.
- `HaltReq`  input  1  halt instruction decoded.
- `NextAddress`  output  32  drives PC `Address`.
- `PCWrite`  output  1  to PC; 1 = hold, 0 = load.
- `IFIDWrite`  output  1  1 = hold IF/ID register.
- `IFIDFlush`  output  1  zero IF/ID contents.
- `IDEXFlush`  output  1  insert bubble into ID/EX.
- `Halted`  output  1  sequencer is in HALT.

Behaviour:
- Clock and reset: one clock, `Clk`. `Reset` is synchronous and active-high; all state changes on posedge `Clk`.
- Reset values:
  - state = RUN, stall counter = 0.
  - While `Reset`=1: `NextAddress`=`RESET_VECTOR`, `PCWrite`=0, `IFIDWrite`=0, `IFIDFlush`=1, `IDEXFlush`=1, `Halted`=0.
- Outputs are combinational from state and inputs, so a decision takes effect at the PC on the next posedge (zero-cycle decision latency).
- States:
  - RUN: normal fetch.
  - STALL: counter-driven bubble insertion.
  - HALT: fetch frozen.
- Load-use hazard, `luh` = `IDEX_MemRead` && `IDEX_Rt`!=0 && (`IDEX_Rt`==`IFID_Rs` || `IDEX_Rt`==`IFID_Rt`).
- Per-cycle priority, highest first:
  1. `Reset`.
  2. HALT state: `PCWrite`=1, `IFIDWrite`=1, `IDEXFlush`=1, `Halted`=1. Only `Reset` exits HALT; all other inputs are ignored.
  3. `HaltReq` (RUN or STALL): `PCWrite`=1, `IFIDFlush`=1; next state HALT.
  4. `BranchTaken`: `NextAddress`=`BranchTarget`, `PCWrite`=0, `IFIDFlush`=1, `IDEXFlush`=1. Any STALL is cancelled (counter cleared, next state RUN).
  5. `Jump`: `NextAddress`=`JumpTarget`, `PCWrite`=0, `IFIDFlush`=1. Cancels STALL the same way.
  6. `luh` in RUN: `PCWrite`=1, `IFIDWrite`=1, `IDEXFlush`=1.
     - If `LOAD_STALL_CYCLES`>1: counter loads `LOAD_STALL_CYCLES`-1 and next state is STALL.
     - Otherwise stay in RUN.
  7. STALL: same holds and flush as item 6; counter decrements each cycle; on the cycle the counter reaches 1, next state is RUN. `luh` is not re-evaluated in STALL.
  8. Default RUN: `NextAddress`=`PCCurrent`+4 (modulo 2^32, 32'hFFFFFFFC wraps to 0), `PCWrite`=0, all flushes and holds 0.
- `NextAddress` is don't-care whenever `PCWrite`=1; drive `PCCurrent`+4 there for determinism.
- `BranchTaken` and `Jump` asserted together: the branch wins (older instruction); the jump is discarded by `IFIDFlush`.
- Targets are passed through unmodified; no alignment checking.

Optional Feature:
- Macro: `PC_SEQ_PERF_COUNTERS_EN`.
- Defined: adds outputs `CycleCount`, `StallCount` and `FlushCount`, each 32 bits.
  - All clear on `Reset`.
  - `CycleCount` increments every non-halted cycle.
  - `StallCount` increments in each cycle where `PCWrite`=1 due to `luh` or STALL.
  - `FlushCount` increments on each branch/jump redirect.
  - All three saturate at 32'hFFFFFFFF.
- Undefined: ports and logic are absent; core behaviour is identical.

Decomposition:
- Shared package `datapath_pkg`: state enum (RUN, STALL, HALT); constants `PC_INCR`=4, `REG_ZERO`=5'd0, `RESET_VECTOR` default.
- One natural sub-module `hazard_detect`: purely combinational `luh` compare, reusable by forwarding logic.
- FSM, counter and next-address mux stay in `pc_sequencer`.

Test Plan:
1. Reset held 2 cycles, then released, with `PCCurrent` driven back from `NextAddress` -> `NextAddress`=0, then 4, 8, 12 on consecutive cycles; `PCWrite`=0.
2. `IDEX_MemRead`=1, `IDEX_Rt`=8, `IFID_Rs`=8, with `LOAD_STALL_CYCLES`=2 -> `PCWrite`=1 and `IDEXFlush`=1 for exactly 2 cycles, then sequential fetch resumes.
3. Same stimulus with `IDEX_Rt`=0 -> no stall.
4. `BranchTaken`=1, `BranchTarget`=32'h40, in the second cycle of a 3-cycle stall -> `NextAddress`=32'h40, `PCWrite`=0, `IFIDFlush`=1; next cycle state RUN with `NextAddress`=32'h44.
5. `BranchTaken`=1 (target 32'h100) and `Jump`=1 (target 32'h200) together -> `NextAddress`=32'h100.
6. `HaltReq` pulse -> `Halted`=1 and `PCWrite`=1 indefinitely, ignoring `BranchTaken`; `Reset` -> `NextAddress`=0, `Halted`=0.
